// File: rtl/via_link_pkg.sv
// Shared types and constants for the VIA CB1/CB2 serial link engine.
package via_link_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTx,
    StWaitRx,
    StRx
  } link_state_e;

  localparam logic MODE_PLUS = 1'b0;
  localparam logic MODE_ADB  = 1'b1;

endpackage

// File: rtl/link_fifo.sv
// Synchronous device-to-host byte FIFO; a push while full is accepted only if a pop
// happens on the same cycle.
module link_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic              do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_q];
  assign level   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/via_shift_link.sv
// VIA CB1/CB2 shift-clock generator and serialiser for Mac Plus keyboard or SE ADB
// transfers, with an RX FIFO buffering device replies.
module via_shift_link
  import via_link_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned HALF_PLUS = 1301,
  parameter int unsigned HALF_ADB  = 169,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned RX_DEPTH  = 4
) (
  input  logic                        clk32,
  input  logic                        _reset,
  input  logic                        clk8_en_p,
  input  logic                        mode,
  input  logic                        host_dat_i,
  input  logic                        adb_listen,
  output logic                        shift_clk,
  output logic                        dev_dat_o,
  input  logic                        rx_push,
  input  logic [DATA_W-1:0]           rx_din,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_strobe,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic                        busy,
  output logic                        overflow
);

  localparam int unsigned BW = $clog2(DATA_W);

  link_state_e       state_q;
  logic              cur_mode_q;
  logic              attn_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] rx_byte_q;

  logic [CNT_W-1:0]  half_m1;
  logic              active, toggle, fall, rise, last;
  logic              adb_tx_start, tx_start, rx_start, pop_req;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;

  assign half_m1 = (cur_mode_q == MODE_ADB) ? CNT_W'(HALF_ADB - 1) : CNT_W'(HALF_PLUS - 1);
  assign active  = (state_q == StTx) || (state_q == StRx);
  assign toggle  = active && (cnt_q == half_m1);
  assign fall    = toggle && shift_clk;
  assign rise    = toggle && !shift_clk;
  assign last    = rise && (bit_cnt_q == BW'(DATA_W - 1));

  assign adb_tx_start = (state_q == StIdle) && (mode == MODE_ADB) && attn_q && adb_listen;
  assign tx_start     = adb_tx_start ||
                        ((state_q == StIdle) && (mode == MODE_PLUS) && !host_dat_i);
  // A pending host command always beats a buffered device reply.
  assign rx_start     = ((state_q == StIdle) && (mode == MODE_ADB) && !fifo_empty && !tx_start) ||
                        ((state_q == StWaitRx) && host_dat_i && !fifo_empty);
  assign pop_req      = clk8_en_p && rx_start;
  assign busy         = (state_q != StIdle);

  link_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RX_DEPTH)
  ) u_fifo (
    .clk   (clk32),
    .rst_n (_reset),
    .push  (clk8_en_p && rx_push),
    .pop   (pop_req),
    .din   (rx_din),
    .dout  (fifo_dout),
    .level (rx_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      state_q    <= StIdle;
      cur_mode_q <= MODE_PLUS;
      attn_q     <= 1'b1;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_byte_q  <= '0;
      shift_clk  <= 1'b1;
      dev_dat_o  <= 1'b1;
      tx_data    <= '0;
      tx_strobe  <= 1'b0;
      overflow   <= 1'b0;
    end else if (clk8_en_p) begin
      tx_strobe <= 1'b0;
      if (rx_push && fifo_full && !pop_req) overflow <= 1'b1;

      if (!active) begin
        cnt_q     <= '0;
        shift_clk <= 1'b1;
      end else if (toggle) begin
        cnt_q     <= '0;
        shift_clk <= ~shift_clk;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (fall && state_q == StTx) tx_shift_q <= {tx_shift_q[DATA_W-2:0], host_dat_i};
      if (fall && state_q == StRx) dev_dat_o <= rx_byte_q[BW'(DATA_W - 1) - bit_cnt_q];
      if (rise) bit_cnt_q <= last ? '0 : bit_cnt_q + BW'(1);

      unique case (state_q)
        StIdle: begin
          if (mode == MODE_ADB && host_dat_i) attn_q <= 1'b1;
          if (tx_start) begin
            state_q    <= StTx;
            cur_mode_q <= mode;
            if (adb_tx_start) attn_q <= 1'b0;
          end else if (rx_start) begin
            state_q    <= StRx;
            cur_mode_q <= mode;
            rx_byte_q  <= fifo_dout;
          end
        end
        StTx: begin
          if (last) begin
            tx_strobe <= 1'b1;
            tx_data   <= tx_shift_q;
            state_q   <= (cur_mode_q == MODE_PLUS) ? StWaitRx : StIdle;
          end
        end
        StWaitRx: begin
          if (rx_start) begin
            state_q   <= StRx;
            rx_byte_q <= fifo_dout;
          end
        end
        StRx: begin
          if (last) begin
            state_q   <= StIdle;
            dev_dat_o <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_via_shift_link.sv
// Randomised bench for via_shift_link: a host agent shifts bytes, a queue models the RX FIFO.
module tb_via_shift_link;

  localparam int unsigned HP    = 37;
  localparam int unsigned HA    = 11;
  localparam int unsigned DEPTH = 4;
  localparam int          LIMIT = 20000;

  logic       clk32 = 1'b0;
  logic       _reset = 1'b0;
  logic       clk8_en_p = 1'b0;
  logic       mode = 1'b0;
  logic       host_dat_i = 1'b1;
  logic       adb_listen = 1'b0;
  logic       shift_clk, dev_dat_o, tx_strobe, busy, overflow;
  logic       rx_push = 1'b0;
  logic [7:0] rx_din = '0;
  logic [7:0] tx_data;
  logic [2:0] rx_level;

  via_shift_link #(
    .DATA_W    (8),
    .HALF_PLUS (HP),
    .HALF_ADB  (HA),
    .CNT_W     (11),
    .RX_DEPTH  (DEPTH)
  ) dut (
    .clk32      (clk32),
    ._reset     (_reset),
    .clk8_en_p  (clk8_en_p),
    .mode       (mode),
    .host_dat_i (host_dat_i),
    .adb_listen (adb_listen),
    .shift_clk  (shift_clk),
    .dev_dat_o  (dev_dat_o),
    .rx_push    (rx_push),
    .rx_din     (rx_din),
    .tx_data    (tx_data),
    .tx_strobe  (tx_strobe),
    .rx_level   (rx_level),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk32 = ~clk32;

  int n_tests = 0;
  int n_fail  = 0;

  // Observed link activity, gathered on the falling clk32 edge.
  int         en_total = 0, last_edge_en = 0;
  int         rises = 0, falls = 0, strobes = 0, cap_rises = 0;
  int         min_half = 32'hFFFF, max_half = 0;
  logic [7:0] dev_shift = '0, cap_data = '0;
  logic       prev_sclk = 1'b1, prev_busy = 1'b0, prev_strobe = 1'b0;

  // Reference FIFO contents and sticky overflow.
  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;

  always @(negedge clk32) begin
    int half;
    if (_reset && clk8_en_p) en_total++;
    if (busy && !prev_busy) last_edge_en = en_total;
    if (_reset && shift_clk !== prev_sclk) begin
      half = en_total - last_edge_en;
      last_edge_en = en_total;
      if (half < min_half) min_half = half;
      if (half > max_half) max_half = half;
      if (!shift_clk) begin
        falls++;
        dev_shift = {dev_shift[6:0], dev_dat_o};
      end else begin
        rises++;
      end
    end
    if (tx_strobe && !prev_strobe) begin
      strobes++;
      cap_data  = tx_data;
      cap_rises = rises;
    end
    prev_sclk   = shift_clk;
    prev_busy   = busy;
    prev_strobe = tx_strobe;
    clk8_en_p   = ($urandom_range(0, 2) != 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk32);
    #1;
  endtask

  // Return when the next rising clk32 edge carries an enable.
  task automatic wait_en();
    for (int i = 0; i < 1000 && !clk8_en_p; i++) step();
  endtask

  task automatic clear_stats();
    rises = 0; falls = 0; strobes = 0; cap_rises = 0;
    min_half = 32'hFFFF; max_half = 0; dev_shift = '0;
    last_edge_en = en_total;
  endtask

  task automatic wait_busy(input logic val, input string tag);
    for (int i = 0; i < LIMIT && busy !== val; i++) step();
    check(tag, busy, val);
  endtask

  task automatic wait_rises(input int target, input string tag);
    for (int i = 0; i < LIMIT && rises < target; i++) step();
    check(tag, rises, target);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wait_en();
    rx_din  = b;
    rx_push = 1'b1;
    step();
    rx_push = 1'b0;
    if (model_q.size() == DEPTH) model_ovf = 1'b1;
    else model_q.push_back(b);
  endtask

  // Host shifts one byte; toggle_at > 0 flips mode after that many rising edges.
  task automatic host_byte(input logic [7:0] b, input logic adb, input int toggle_at);
    clear_stats();
    mode = adb;
    if (adb) begin
      host_dat_i = 1'b1;
      repeat (3) step();
      adb_listen = 1'b1;
    end else begin
      host_dat_i = 1'b0;
    end
    wait_busy(1'b1, "tx_start");
    adb_listen = 1'b0;
    host_dat_i = b[7];
    for (int i = 1; i < 8; i++) begin
      wait_rises(i, "tx_rise");
      host_dat_i = b[7-i];
      if (i == toggle_at) mode = ~mode;
    end
    for (int i = 0; i < LIMIT && strobes < 1; i++) step();
    host_dat_i = 1'b0;
    check("tx_strobe_seen", strobes, 1);
    check("tx_data", cap_data, b);
    check("tx_rises_at_strobe", cap_rises, 8);
    check("tx_half_min", min_half, adb ? HA : HP);
    check("tx_half_max", max_half, adb ? HA : HP);
    check("tx_busy_after", busy, !adb);
  endtask

  task automatic plus_reply();
    logic [7:0] exp;
    exp = model_q.pop_front();
    wait_en();
    host_dat_i = 1'b1;
    step();
    clear_stats();
    check("plus_rx_level", rx_level, model_q.size());
    wait_busy(1'b0, "plus_rx_done");
    check("plus_rx_byte", dev_shift, exp);
    check("plus_rx_falls", falls, 8);
    check("plus_rx_half", max_half, HP);
  endtask

  task automatic adb_reply(input logic [7:0] b);
    logic [7:0] exp;
    clear_stats();
    push_byte(b);
    check("adb_push_idle", busy, 1'b0);
    check("adb_push_level", rx_level, model_q.size());
    wait_en();
    step();
    exp = model_q.pop_front();
    check("adb_rx_next_en", busy, 1'b1);
    check("adb_rx_level", rx_level, model_q.size());
    wait_busy(1'b0, "adb_rx_done");
    check("adb_rx_byte", dev_shift, exp);
    check("adb_rx_half_min", min_half, HA);
    check("adb_rx_half_max", max_half, HA);
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) step();
    check("rst_sclk", shift_clk, 1'b1);
    check("rst_dev", dev_dat_o, 1'b1);
    check("rst_strobe", tx_strobe, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_level", rx_level, 0);
    _reset = 1'b1;
    repeat (3) step();
    check("idle_busy", busy, 1'b0);

    // Plus keyboard: fixed vectors first, then random traffic.
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h10 : 8'($urandom_range(0, 255));
      host_byte(b, 1'b0, 0);
      push_byte((k == 0) ? 8'h7B : 8'($urandom_range(0, 255)));
      check("plus_level_pre", rx_level, model_q.size());
      plus_reply();
    end

    // ADB command then device reply.
    for (int k = 0; k < 2; k++) begin
      host_byte((k == 0) ? 8'h3C : 8'($urandom_range(0, 255)), 1'b1, 0);
      adb_reply((k == 0) ? 8'h55 : 8'($urandom_range(0, 255)));
    end

    // Overflow, then push and pop on the same enable while full.
    mode = 1'b0;
    host_dat_i = 1'b1;
    step();
    for (int k = 0; k < 5; k++) push_byte(8'($urandom_range(0, 255)));
    check("ovf_level", rx_level, model_q.size());
    check("ovf_flag", overflow, model_ovf);
    host_byte(8'($urandom_range(0, 255)), 1'b0, 0);
    b = 8'($urandom_range(0, 255));
    wait_en();
    host_dat_i = 1'b1;
    rx_din = b;
    rx_push = 1'b1;
    step();
    rx_push = 1'b0;
    clear_stats();
    begin
      logic [7:0] exp;
      exp = model_q.pop_front();
      model_q.push_back(b);
      check("full_pushpop_level", rx_level, model_q.size());
      wait_busy(1'b0, "full_rx_done");
      check("full_rx_byte", dev_shift, exp);
      check("ovf_sticky", overflow, model_ovf);
    end

    // Reset in the middle of a Plus transfer.
    clear_stats();
    mode = 1'b0;
    host_dat_i = 1'b0;
    wait_busy(1'b1, "rst_tx_start");
    host_dat_i = 1'b1;
    wait_rises(3, "rst_tx_rise");
    _reset = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    check("midrst_sclk", shift_clk, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_level", rx_level, 0);
    check("midrst_ovf", overflow, 1'b0);
    repeat (2) step();
    _reset = 1'b1;
    repeat (4) step();
    check("midrst_no_strobe", strobes, 0);
    host_byte(8'($urandom_range(0, 255)), 1'b0, 0);
    push_byte(8'($urandom_range(0, 255)));
    plus_reply();

    // Mode flips mid-transfer: Plus timing and WAIT_RX must still apply.
    host_byte(8'($urandom_range(0, 255)), 1'b0, 3);
    push_byte(8'($urandom_range(0, 255)));
    plus_reply();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
